// File: rtl/wbm_pkg.sv
// wbm_pkg: shared FSM state type and Wishbone constants for the block-transfer master
package wbm_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, REQ, PUSH, DONE} state_t;
  localparam logic [3:0] WB_SEL_ALL = 4'hF;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/wbm_timeout_timer.sv
// wbm_timeout_timer: per-beat ack watchdog; clk/rst, clear restarts, enable counts, expired on the TIMEOUT-th cycle
module wbm_timeout_timer
  import wbm_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign expired = cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/wbm_block_xfer.sv
// wbm_block_xfer: Wishbone master moving cmd_len words between the wr/rd streams and the bus
// Ports: wb_clk_i/wb_rst_i clock and async reset; cmd_* command handshake; wr_* write-data in;
//        rd_* read-data out; wbm_* Wishbone master; busy, done pulse, err pulse on ack timeout
module wbm_block_xfer
  import wbm_pkg::*;
#(
  parameter int BITS = 32,
  parameter int LEN_W = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [BITS-1:0]  cmd_adr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [BITS-1:0]  wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [BITS-1:0]  rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [BITS-1:0]  wbm_adr_o,
  output logic [BITS-1:0]  wbm_dat_o,
  input  logic [BITS-1:0]  wbm_dat_i,
  input  logic             wbm_ack_i,
  output logic             busy,
  output logic             done,
  output logic             err
);
  state_t state, nxt;
  logic [LEN_W-1:0] rem;
  logic we, expired;
  wbm_timeout_timer #(.TIMEOUT(TIMEOUT)) u_tmr (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .clear(state != REQ),
    .enable(state == REQ),
    .expired(expired)
  );
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (cmd_valid) nxt = cmd_len == '0 ? DONE : cmd_we ? FETCH : REQ;
      FETCH: if (wr_valid) nxt = REQ;
      // write decides on the pre-decrement count, so the last beat is rem == 1
      REQ:   if (wbm_ack_i) nxt = !we ? PUSH : rem == LEN_W'(1) ? DONE : FETCH;
             else if (expired) nxt = IDLE;
      PUSH:  if (rd_ready) nxt = rem == '0 ? DONE : REQ;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
    cmd_ready = state == IDLE;
    busy = state != IDLE;
    wr_ready = state == FETCH;
    rd_valid = state == PUSH;
    done = state == DONE;
    wbm_cyc_o = state == REQ;
    wbm_stb_o = state == REQ;
    wbm_we_o = state == REQ && we;
    wbm_sel_o = state == REQ ? WB_SEL_ALL : 4'h0;
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rd_data <= '0;
      rem <= '0;
      we <= 1'b0;
      err <= 1'b0;
    end else begin
      err <= state == REQ && expired && !wbm_ack_i;
      if (state == IDLE && cmd_valid) begin
        wbm_adr_o <= cmd_adr & ~BITS'(3);
        rem <= cmd_len;
        we <= cmd_we;
      end
      if (state == FETCH && wr_valid) wbm_dat_o <= wr_data;
      if (state == REQ && wbm_ack_i) begin
        wbm_adr_o <= wbm_adr_o + BITS'(WORD_BYTES);
        rem <= rem - 1'b1;
        if (!we) rd_data <= wbm_dat_i;
      end
    end
endmodule

// File: tb/tb_wbm_block_xfer.sv
// tb_wbm_block_xfer: directed bench with a Wishbone slave model for wbm_block_xfer
module tb_wbm_block_xfer;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, cmd_we = 0;
  logic [31:0] cmd_adr = 0;
  logic [7:0] cmd_len = 0;
  logic [31:0] wr_data;
  logic wr_valid = 0, wr_ready;
  logic [31:0] rd_data;
  logic rd_valid, rd_ready = 1;
  logic cyc, stb, we, ack;
  logic [3:0] sel;
  logic [31:0] adr, dat_o, dat_i;
  logic busy, done, err;
  int n_tot = 0, n_bad = 0;
  int ack_dly = 1, wcnt;
  logic no_ack = 0;
  logic [31:0] mem [0:255];
  int wr_idx = 0;
  int b_n = 0, rd_n = 0, done_n = 0, err_n = 0, stb_n = 0, gap_bad = 0;
  logic prev_ack = 0;
  logic [31:0] adr_log [0:63];
  logic [31:0] rd_log [0:63];
  logic we_log [0:63];
  logic [3:0] sel_log [0:63];
  int s_b, s_rd, s_d, s_e, s_s;
  logic [31:0] d0;
  logic stable;

  always #5 clk = ~clk;

  wbm_block_xfer dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_adr(cmd_adr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack),
    .busy(busy), .done(done), .err(err)
  );

  assign wr_data = 32'hA5A5_0001 + wr_idx;

  always @(posedge clk) if (wr_valid && wr_ready) wr_idx <= wr_idx + 1;

  always @(posedge clk or posedge rst)
    if (rst) begin
      ack <= 0; wcnt <= 0; dat_i <= 0;
    end else if (!(cyc && stb) || ack) begin
      ack <= 0; wcnt <= 0;
    end else if (!no_ack && wcnt == ack_dly - 1) begin
      ack <= 1;
      dat_i <= adr ^ 32'hC0DE_0000;
      if (we) mem[adr[9:2]] <= dat_o;
    end else wcnt <= wcnt + 1;

  always @(negedge clk) begin
    if (cyc && stb && ack && b_n < 64) begin
      adr_log[b_n] = adr; we_log[b_n] = we; sel_log[b_n] = sel; b_n++;
    end
    if (rd_valid && rd_ready && rd_n < 64) begin
      rd_log[rd_n] = rd_data; rd_n++;
    end
    if (done) done_n++;
    if (err) err_n++;
    if (stb) stb_n++;
    if (prev_ack && stb) gap_bad++;
    prev_ack = cyc && stb && ack;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_cmd(input logic w, input logic [31:0] a, input logic [7:0] l);
    cmd_we = w; cmd_adr = a; cmd_len = l; cmd_valid = 1;
    @(posedge clk); #1 cmd_valid = 0;
  endtask

  task automatic wait_idle(input int max);
    int i = 0;
    @(negedge clk);
    while (busy && i < max) begin @(negedge clk); i++; end
    chk("idle", {31'd0, busy}, 0);
    @(negedge clk);
  endtask

  task automatic snap;
    s_b = b_n; s_rd = rd_n; s_d = done_n; s_e = err_n; s_s = stb_n;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_valid = 1;
    #3;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
    chk("rst_cyc", {31'd0, cyc}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_adr", adr, 0);
    @(negedge clk); rst = 0;

    ack_dly = 12; snap;
    do_cmd(0, 32'h3800_0000, 4); wait_idle(200);
    chk("rd4_beats", b_n - s_b, 4);
    for (int k = 0; k < 4; k++) begin
      chk("rd4_adr", adr_log[s_b + k], 32'h3800_0000 + 4 * k);
      chk("rd4_data", rd_log[s_rd + k], 32'hF8DE_0000 + 4 * k);
    end
    chk("rd4_done", done_n - s_d, 1);
    chk("rd4_gap", gap_bad, 0);
    chk("rd4_stb_cycles", stb_n - s_s, 52);

    ack_dly = 2; snap;
    do_cmd(1, 32'h3800_0010, 3); wait_idle(200);
    for (int k = 0; k < 3; k++) begin
      chk("wr3_mem", mem[4 + k], 32'hA5A5_0001 + k);
      chk("wr3_adr", adr_log[s_b + k], 32'h3800_0010 + 4 * k);
      chk("wr3_we", {31'd0, we_log[s_b + k]}, 1);
      chk("wr3_sel", {28'd0, sel_log[s_b + k]}, 32'hF);
    end
    chk("wr3_done", done_n - s_d, 1);

    ack_dly = 3; snap;
    @(posedge clk); #1 rd_ready = 0;
    do_cmd(0, 32'h0000_0100, 2);
    for (int i = 0; i < 100 && !rd_valid; i++) @(negedge clk);
    chk("hold_valid", {31'd0, rd_valid}, 1);
    d0 = rd_data;
    chk("hold_data", d0, 32'hC0DE_0100);
    s_s = stb_n; stable = 1;
    repeat (20) begin
      @(negedge clk);
      if (!rd_valid || rd_data !== d0 || cyc) stable = 0;
    end
    chk("hold_stable", {31'd0, stable}, 1);
    chk("hold_nobus", stb_n - s_s, 0);
    @(posedge clk); #1 rd_ready = 1;
    wait_idle(100);
    chk("hold_count", rd_n - s_rd, 2);
    chk("hold_data2", rd_log[rd_n - 1], 32'hC0DE_0104);

    no_ack = 1; snap;
    do_cmd(0, 32'h0, 1); wait_idle(300);
    chk("to_stb_cycles", stb_n - s_s, 64);
    chk("to_err", err_n - s_e, 1);
    chk("to_no_done", done_n - s_d, 0);
    chk("to_idle", {31'd0, cmd_ready}, 1);

    no_ack = 0; ack_dly = 1; snap;
    do_cmd(0, 32'h40, 0);
    @(negedge clk);
    chk("len0_done_now", {31'd0, done}, 1);
    wait_idle(20);
    chk("len0_no_cyc", stb_n - s_s, 0);
    chk("len0_done_once", done_n - s_d, 1);

    no_ack = 1;
    do_cmd(0, 32'h80, 2);
    repeat (3) @(negedge clk);
    chk("mid_stb", {31'd0, stb}, 1);
    #2 rst = 1;
    #1;
    chk("mid_rst_cyc", {31'd0, cyc}, 0);
    chk("mid_rst_stb", {31'd0, stb}, 0);
    chk("mid_rst_ready", {31'd0, cmd_ready}, 1);
    @(negedge clk); rst = 0; no_ack = 0; ack_dly = 1; snap;

    do_cmd(0, 32'hFFFF_FFFC, 2);
    chk("post_rst_accept", {31'd0, busy}, 1);
    wait_idle(100);
    chk("wrap_beats", b_n - s_b, 2);
    chk("wrap_adr0", adr_log[s_b], 32'hFFFF_FFFC);
    chk("wrap_adr1", adr_log[s_b + 1], 32'h0000_0000);
    chk("wrap_data0", rd_log[s_rd], 32'h3F21_FFFC);
    chk("wrap_data1", rd_log[s_rd + 1], 32'hC0DE_0000);
    chk("wrap_done", done_n - s_d, 1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/wbm_block_xfer.md
WBM_BLOCK_XFER -- requirements
Module: wbm_block_xfer

Interface
REQ-001 Parameter BITS, default 32, data and address width.
REQ-002 Parameter LEN_W, default 8, width of the transfer word count.
REQ-003 Parameter TIMEOUT, default 64, max cycles to wait for ack per beat.
REQ-004 wb_clk_i  in  1  sole clock; all state on rising edge.
REQ-005 wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high.
REQ-008 cmd_we  in  1  1 = write block, 0 = read block.
REQ-009 cmd_adr  in  BITS  start byte address; bits [1:0] ignored.
REQ-010 cmd_len  in  LEN_W  number of 32-bit words.
REQ-011 wr_data/wr_valid/wr_ready  in/in/out  BITS/1/1  write-data stream.
REQ-012 rd_data/rd_valid/rd_ready  out/out/in  BITS/1/1  read-data stream.
REQ-013 wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone master controls.
REQ-014 wbm_sel_o  out  4  byte selects; wbm_adr_o, wbm_dat_o  out  BITS.
REQ-015 wbm_dat_i  in  BITS; wbm_ack_i  in  1  slave read data and acknowledge.
REQ-016 busy  out  1; done  out  1 (1-cycle pulse); err  out  1 (1-cycle pulse, timeout).

Function
REQ-017 States: IDLE, FETCH, REQ, PUSH, DONE; cmd_ready high only in IDLE.
REQ-018 Accept in IDLE: latch address (bits [1:0] = 0), length, direction; len 0 -> DONE, no bus cycle; else write -> FETCH, read -> REQ.
REQ-019 FETCH: wr_ready high; on wr_valid latch wr_data into wbm_dat_o, go REQ next cycle.
REQ-020 REQ: wbm_cyc_o = wbm_stb_o = 1, wbm_sel_o = 4'hF, wbm_we_o = latched direction, all held stable until ack.
REQ-021 On sampled wbm_ack_i in REQ: cyc/stb low next cycle (at least one idle cycle between beats), address += 4 with 32-bit wrap, remaining -= 1.
REQ-022 Write ack: remaining 0 -> DONE, else FETCH.
REQ-023 Read ack: capture wbm_dat_i into rd_data, go PUSH; rd_valid high, rd_data stable until rd_ready; then remaining 0 -> DONE, else REQ.
REQ-024 wbm_ack_i outside REQ is ignored.
REQ-025 Timeout: per-beat counter cleared on entering REQ; if TIMEOUT cycles elapse without ack, drop cyc/stb, pulse err, return to IDLE (done not pulsed); ack arriving on the timeout cycle wins.
REQ-026 DONE: done pulses one cycle, then IDLE.
REQ-027 busy high in every state except IDLE.
REQ-028 Address 0xFFFF_FFFC increments to 0x0000_0000.

Reset
REQ-029 While wb_rst_i high: state IDLE, cmd_ready 1, all other outputs 0, counters 0, immediately (asynchronous), including mid-transfer.
REQ-030 First command accepted on first rising edge after wb_rst_i deasserts.

Structure
REQ-031 Package wbm_pkg holds the state enum, WB_SEL_ALL = 4'hF, WORD_BYTES = 4.
REQ-032 One sub-module, wbm_timeout_timer: clear/enable inputs, expired output, parameter TIMEOUT.

Verification
REQ-033 Read 4 words @0x3800_0000, slave ack after 12 cycles, rd_ready always 1 -> 4 beats at 0x3800_0000/04/08/0C, data in order, done once, stb low between beats.
REQ-034 Write 3 words 0xA5A5_0001..3 @0x3800_0010 -> wbm_we_o 1, sel 4'hF, slave memory holds values, done pulse.
REQ-035 Read with rd_ready held low 20 cycles -> rd_valid/rd_data stable, no new bus cycle until accepted.
REQ-036 Slave never acks, TIMEOUT 64 -> stb high exactly 64 cycles, err one pulse, no done, back to IDLE.
REQ-037 cmd_len 0 -> no cyc, done one cycle later; wb_rst_i mid-REQ -> cyc/stb drop same cycle, cmd_ready 1.
REQ-038 Read 2 words @0xFFFF_FFFC -> addresses 0xFFFF_FFFC then 0x0000_0000.
